md5_round_ctrl: RTL and testbench
=================================

MD5_ROUND_CTRL -- requirements
Module: md5_round_ctrl

Interface
REQ-001 The block SHALL have no parameters; all constants (shift amounts, T table) SHALL be fixed internal values.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to hash one 512-bit block; sampled only in IDLE.
REQ-006 block_in  input  512  message block; word k = block_in[32k+31:32k], k=0..15.
REQ-007 chain_in  input  128  input chaining value; A=[31:0], B=[63:32], C=[95:64], D=[127:96].
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 done  output  1  one-cycle pulse; digest_out valid.
REQ-010 digest_out  output  128  result, same packing as chain_in.
REQ-011 rnd_a, rnd_b, rnd_c, rnd_d  output  32 each  working registers A..D driven to the external round datapath.
REQ-012 rnd_message, rnd_s, rnd_t  output  32 each  message word, rotate amount and additive constant for the current step.
REQ-013 rnd_sel  output  2  round-function select: 00=F, 01=G, 10=H, 11=I.
REQ-014 a_next  input  32  combinational step result returned by the round datapath.

Function
REQ-015 The block SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE, with state = IDLE after reset.
REQ-016 IDLE transition: on a clk edge with start=1, the block SHALL latch block_in into a 16x32 message buffer, load A..D from chain_in, latch chain_in, set step=0, and go to RUN.
REQ-017 Start handling outside IDLE: start SHALL be ignored in RUN and DONE, with no effect on any state.
REQ-018 RUN, each edge: the block SHALL commit one step as A<=D, B<=a_next, C<=B, D<=C, then step<=step+1 (6-bit counter).
REQ-019 RUN exit: the edge that commits step 63 SHALL move the FSM to DONE, so RUN lasts exactly 64 cycles.
REQ-020 DONE, single edge: the block SHALL load digest_out from A..D (see REQ-030), pulse done high for that one cycle, and return to IDLE.
REQ-021 Latency: done SHALL rise exactly 65 edges after the edge that accepts start; a new start is accepted no earlier than the following IDLE edge.
REQ-022 rnd_sel SHALL equal step[5:4].
REQ-023 rnd_message SHALL be word index i for steps 0-15, (5i+1) mod 16 for 16-31, (3i+5) mod 16 for 32-47, and (7i) mod 16 for 48-63, where i = step.
REQ-024 rnd_s SHALL cycle by step[1:0] through {7,12,17,22}, {5,9,14,20}, {4,11,16,23} and {6,10,15,21} for rounds 1-4.
REQ-025 rnd_t SHALL equal T[step] = floor(|sin(step+1)| * 2^32), from a 64-entry constant ROM.
REQ-026 Round outputs outside RUN: rnd_* outputs SHALL be combinational from step and the registers, with step held at 0 outside RUN.
REQ-027 Arithmetic: all additions SHALL be modulo 2^32, and carries SHALL be discarded.
REQ-028 Output hold: digest_out SHALL hold its value until the next DONE; busy = (state != IDLE).

Reset
REQ-029 On rst=1 the block SHALL asynchronously go to IDLE and clear step, A..D, the message buffer, the latched chain, digest_out, done and busy to 0; a reset in RUN SHALL abort the hash with no done pulse.

Configuration
REQ-030 With macro MD5_FINAL_ADD_EN defined, digest_out SHALL be the per-word sum of the latched chain_in and A..D (the MD5 feed-forward); without it, digest_out SHALL be the raw A..D, and the chain-latch register SHALL NOT be implemented.

Verification
REQ-031 Empty-message test (MD5_FINAL_ADD_EN): chain_in = {10325476,98badcfe,efcdab89,67452301}, word0 = 00000080, all other words 0, start -> done at edge 65 with digest_out = {7e42f8ec,980980e9,04b2008f,d98c1dd4} ("d41d8cd9...27e").
REQ-032 "abc" test (MD5_FINAL_ADD_EN): same chain_in, word0 = 80636261, word14 = 00000018, others 0 -> digest_out = {727fe128,7d3f96d6,b04fd23c,98500190}.
REQ-033 Round-drive check: step 0 -> rnd_sel=00, rnd_s=7, rnd_t=d76aa478, word0; step 16 -> 01, 5, f61e2562, word1; step 32 -> 10, 4, fffa3942, word5; step 48 -> 11, 6, f4292244, word0.
REQ-034 Start held high throughout RUN -> exactly one done in 66 cycles; with start still high, the next hash is accepted on the IDLE edge after DONE.
REQ-035 rst pulsed at step 30 -> busy=0 and done=0 immediately, with no done afterwards; a subsequent normal start reproduces the REQ-031 result.
REQ-036 Without MD5_FINAL_ADD_EN, the REQ-031 stimulus -> each digest_out word equals the REQ-031 word minus the matching chain_in word, mod 2^32.

Source files
------------

// File: rtl/md5_round_ctrl_if.sv
// Bus between the MD5 block controller and its user / external round datapath.
// The master drives start, the block, the chaining value and a_next; the slave (controller) drives the rest.
interface md5_round_ctrl_if;
    logic         start;
    logic [511:0] block_in;
    logic [127:0] chain_in;
    logic         busy;
    logic         done;
    logic [127:0] digest_out;
    logic [31:0]  rnd_a;
    logic [31:0]  rnd_b;
    logic [31:0]  rnd_c;
    logic [31:0]  rnd_d;
    logic [31:0]  rnd_message;
    logic [31:0]  rnd_s;
    logic [31:0]  rnd_t;
    logic [1:0]   rnd_sel;
    logic [31:0]  a_next;

    modport master (
        output start, block_in, chain_in, a_next,
        input  busy, done, digest_out, rnd_a, rnd_b, rnd_c, rnd_d,
               rnd_message, rnd_s, rnd_t, rnd_sel
    );

    modport slave (
        input  start, block_in, chain_in, a_next,
        output busy, done, digest_out, rnd_a, rnd_b, rnd_c, rnd_d,
               rnd_message, rnd_s, rnd_t, rnd_sel
    );
endinterface

// File: rtl/md5_round_ctrl.sv
// MD5 64-step sequencer: holds A..D and the message block, feeds an external round datapath.
// Define MD5_FINAL_ADD_EN to add the latched chaining value into the digest (feed-forward).
module md5_round_ctrl (
    input  logic               clk,
    input  logic               rst,
    md5_round_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg;
    logic [5:0]    step_reg;
    logic [31:0]   a_reg, b_reg, c_reg, d_reg;
    logic          busy_reg, done_reg;
    logic [127:0]  digest_reg;
    logic [31:0]   msg_word [16];
    logic          accept;
    logic [3:0]    msg_idx;
    logic [4:0]    s_val;
    logic [31:0]   t_val;
`ifdef MD5_FINAL_ADD_EN
    logic [127:0]  chain_reg;
`endif

    assign accept = (state_reg == IDLE) && bus.start;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_msg
            logic [31:0] word_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    word_reg <= '0;
                else if (accept)
                    word_reg <= bus.block_in[32*gi +: 32];
            end
            assign msg_word[gi] = word_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            step_reg   <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            c_reg      <= '0;
            d_reg      <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            digest_reg <= '0;
`ifdef MD5_FINAL_ADD_EN
            chain_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (bus.start) begin
                        a_reg     <= bus.chain_in[31:0];
                        b_reg     <= bus.chain_in[63:32];
                        c_reg     <= bus.chain_in[95:64];
                        d_reg     <= bus.chain_in[127:96];
`ifdef MD5_FINAL_ADD_EN
                        chain_reg <= bus.chain_in;
`endif
                        step_reg  <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_reg    <= d_reg;
                    b_reg    <= bus.a_next;
                    c_reg    <= b_reg;
                    d_reg    <= c_reg;
                    // Wraps 63 -> 0, so step is already 0 again in DONE.
                    step_reg <= step_reg + 6'd1;
                    if (step_reg == 6'd63)
                        state_reg <= DONE;
                end
                DONE: begin
`ifdef MD5_FINAL_ADD_EN
                    digest_reg <= {chain_reg[127:96] + d_reg, chain_reg[95:64] + c_reg,
                                   chain_reg[63:32]  + b_reg, chain_reg[31:0]  + a_reg};
`else
                    digest_reg <= {d_reg, c_reg, b_reg, a_reg};
`endif
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Message schedule: the four rounds walk the block with different strides.
    always_comb begin
        msg_idx = step_reg[3:0];
        case (step_reg[5:4])
            2'd0:    msg_idx = step_reg[3:0];
            2'd1:    msg_idx = step_reg[3:0] * 4'd5 + 4'd1;
            2'd2:    msg_idx = step_reg[3:0] * 4'd3 + 4'd5;
            default: msg_idx = step_reg[3:0] * 4'd7;
        endcase
    end

    always_comb begin
        s_val = 5'd0;
        case ({step_reg[5:4], step_reg[1:0]})
            4'h0: s_val = 5'd7;   4'h1: s_val = 5'd12;  4'h2: s_val = 5'd17;  4'h3: s_val = 5'd22;
            4'h4: s_val = 5'd5;   4'h5: s_val = 5'd9;   4'h6: s_val = 5'd14;  4'h7: s_val = 5'd20;
            4'h8: s_val = 5'd4;   4'h9: s_val = 5'd11;  4'hA: s_val = 5'd16;  4'hB: s_val = 5'd23;
            4'hC: s_val = 5'd6;   4'hD: s_val = 5'd10;  4'hE: s_val = 5'd15;  4'hF: s_val = 5'd21;
            default: s_val = 5'd0;
        endcase
    end

    // T[i] = floor(|sin(i+1)| * 2^32)
    always_comb begin
        t_val = '0;
        case (step_reg)
            6'd0:  t_val = 32'hd76aa478; 6'd1:  t_val = 32'he8c7b756; 6'd2:  t_val = 32'h242070db; 6'd3:  t_val = 32'hc1bdceee;
            6'd4:  t_val = 32'hf57c0faf; 6'd5:  t_val = 32'h4787c62a; 6'd6:  t_val = 32'ha8304613; 6'd7:  t_val = 32'hfd469501;
            6'd8:  t_val = 32'h698098d8; 6'd9:  t_val = 32'h8b44f7af; 6'd10: t_val = 32'hffff5bb1; 6'd11: t_val = 32'h895cd7be;
            6'd12: t_val = 32'h6b901122; 6'd13: t_val = 32'hfd987193; 6'd14: t_val = 32'ha679438e; 6'd15: t_val = 32'h49b40821;
            6'd16: t_val = 32'hf61e2562; 6'd17: t_val = 32'hc040b340; 6'd18: t_val = 32'h265e5a51; 6'd19: t_val = 32'he9b6c7aa;
            6'd20: t_val = 32'hd62f105d; 6'd21: t_val = 32'h02441453; 6'd22: t_val = 32'hd8a1e681; 6'd23: t_val = 32'he7d3fbc8;
            6'd24: t_val = 32'h21e1cde6; 6'd25: t_val = 32'hc33707d6; 6'd26: t_val = 32'hf4d50d87; 6'd27: t_val = 32'h455a14ed;
            6'd28: t_val = 32'ha9e3e905; 6'd29: t_val = 32'hfcefa3f8; 6'd30: t_val = 32'h676f02d9; 6'd31: t_val = 32'h8d2a4c8a;
            6'd32: t_val = 32'hfffa3942; 6'd33: t_val = 32'h8771f681; 6'd34: t_val = 32'h6d9d6122; 6'd35: t_val = 32'hfde5380c;
            6'd36: t_val = 32'ha4beea44; 6'd37: t_val = 32'h4bdecfa9; 6'd38: t_val = 32'hf6bb4b60; 6'd39: t_val = 32'hbebfbc70;
            6'd40: t_val = 32'h289b7ec6; 6'd41: t_val = 32'heaa127fa; 6'd42: t_val = 32'hd4ef3085; 6'd43: t_val = 32'h04881d05;
            6'd44: t_val = 32'hd9d4d039; 6'd45: t_val = 32'he6db99e5; 6'd46: t_val = 32'h1fa27cf8; 6'd47: t_val = 32'hc4ac5665;
            6'd48: t_val = 32'hf4292244; 6'd49: t_val = 32'h432aff97; 6'd50: t_val = 32'hab9423a7; 6'd51: t_val = 32'hfc93a039;
            6'd52: t_val = 32'h655b59c3; 6'd53: t_val = 32'h8f0ccc92; 6'd54: t_val = 32'hffeff47d; 6'd55: t_val = 32'h85845dd1;
            6'd56: t_val = 32'h6fa87e4f; 6'd57: t_val = 32'hfe2ce6e0; 6'd58: t_val = 32'ha3014314; 6'd59: t_val = 32'h4e0811a1;
            6'd60: t_val = 32'hf7537e82; 6'd61: t_val = 32'hbd3af235; 6'd62: t_val = 32'h2ad7d2bb; 6'd63: t_val = 32'heb86d391;
            default: t_val = '0;
        endcase
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.digest_out  = digest_reg;
    assign bus.rnd_a       = a_reg;
    assign bus.rnd_b       = b_reg;
    assign bus.rnd_c       = c_reg;
    assign bus.rnd_d       = d_reg;
    assign bus.rnd_sel     = step_reg[5:4];
    assign bus.rnd_message = msg_word[msg_idx];
    assign bus.rnd_s       = {27'd0, s_val};
    assign bus.rnd_t       = t_val;
endmodule

// File: tb/tb_md5_round_ctrl.sv
// Scoreboard bench for md5_round_ctrl: an MD5 round datapath closes the loop, a monitor
// pops expected digests / round-drive values as the controller presents them.
module tb_md5_round_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    md5_round_ctrl_if bus();
    md5_round_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    // External round datapath: a_next = B + rotl(A + f(B,C,D) + M + T, s)
    logic [31:0] f_val, sum_val;
    logic [4:0]  sh;
    always_comb begin
        case (bus.rnd_sel)
            2'd0:    f_val = (bus.rnd_b & bus.rnd_c) | (~bus.rnd_b & bus.rnd_d);
            2'd1:    f_val = (bus.rnd_b & bus.rnd_d) | (bus.rnd_c & ~bus.rnd_d);
            2'd2:    f_val = bus.rnd_b ^ bus.rnd_c ^ bus.rnd_d;
            default: f_val = bus.rnd_c ^ (bus.rnd_b | ~bus.rnd_d);
        endcase
        sum_val    = bus.rnd_a + f_val + bus.rnd_message + bus.rnd_t;
        sh         = bus.rnd_s[4:0];
        bus.a_next = bus.rnd_b + ((sum_val << sh) | (sum_val >> (6'd32 - {1'b0, sh})));
    end

    typedef struct {
        string        name;
        logic [127:0] digest;
        logic         chk_digest;
        int           done_cyc;
    } dig_t;

    typedef struct {
        int          step;
        logic [1:0]  sel;
        logic [31:0] s;
        logic [31:0] t;
        logic [31:0] m;
    } drv_t;

    dig_t dig_q[$];
    drv_t drv_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    localparam logic [127:0] CHAIN     = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
    localparam logic [127:0] EMPTY_FIN = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
    localparam logic [127:0] ABC_FIN   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] expect_digest(input logic [127:0] fin);
        logic [127:0] r;
`ifdef MD5_FINAL_ADD_EN
        r = fin;
`else
        for (int w = 0; w < 4; w++)
            r[32*w +: 32] = fin[32*w +: 32] - CHAIN[32*w +: 32];
`endif
        return r;
    endfunction

    // Monitor: round-drive checkpoints while busy, digest + latency on each done pulse.
    int run_c = 0;
    always @(negedge clk) begin
        if (rst || !bus.busy) begin
            run_c = 0;
        end else begin
            if (drv_q.size() != 0 && drv_q[0].step == run_c) begin
                drv_t e;
                e = drv_q.pop_front();
                chk($sformatf("sel_step%0d", e.step), 128'(bus.rnd_sel), 128'(e.sel));
                chk($sformatf("s_step%0d", e.step), 128'(bus.rnd_s), 128'(e.s));
                chk($sformatf("t_step%0d", e.step), 128'(bus.rnd_t), 128'(e.t));
                chk($sformatf("msg_step%0d", e.step), 128'(bus.rnd_message), 128'(e.m));
            end
            run_c++;
        end
        if (!rst && bus.done === 1'b1) begin
            if (dig_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d required no done", cyc);
            end else begin
                dig_t d;
                d = dig_q.pop_front();
                $display("txn %s: digest=%h cycle=%0d", d.name, bus.digest_out, cyc);
                chk({d.name, "_latency"}, 128'(cyc), 128'(d.done_cyc));
                if (d.chk_digest)
                    chk({d.name, "_digest"}, bus.digest_out, d.digest);
            end
        end
    end

    task automatic load_block(input int kind);
        bus.block_in = '0;
        bus.chain_in = CHAIN;
        case (kind)
            0: bus.block_in[31:0] = 32'h00000080;
            1: begin
                bus.block_in[31:0]        = 32'h80636261;
                bus.block_in[14*32 +: 32] = 32'h00000018;
            end
            default: for (int k = 0; k < 16; k++) bus.block_in[32*k +: 32] = 32'h11110000 | 32'(k);
        endcase
    endtask

    task automatic push_drv(input logic [31:0] m0, input logic [31:0] m1, input logic [31:0] m5);
        drv_q.push_back('{0,  2'b00, 32'd7, 32'hd76aa478, m0});
        drv_q.push_back('{16, 2'b01, 32'd5, 32'hf61e2562, m1});
        drv_q.push_back('{32, 2'b10, 32'd4, 32'hfffa3942, m5});
        drv_q.push_back('{48, 2'b11, 32'd6, 32'hf4292244, m0});
    endtask

    task automatic run_hash(input int kind, input string nm, input logic [127:0] fin, input logic chkd);
        @(negedge clk);
        load_block(kind);
        bus.start = 1'b1;
        dig_q.push_back('{nm, expect_digest(fin), chkd, cyc + 66});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (dig_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (dig_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: pending=%0d required 0", nm, dig_q.size());
            dig_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.block_in = '0;
        bus.chain_in = '0;
        #12;
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_done", 128'(bus.done), 128'(0));
        chk("rst_digest", bus.digest_out, 128'(0));
        chk("rst_rnd_a", 128'(bus.rnd_a), 128'(0));
        chk("rst_rnd_d", 128'(bus.rnd_d), 128'(0));
        chk("rst_sel", 128'(bus.rnd_sel), 128'(0));
        chk("rst_t", 128'(bus.rnd_t), 128'(32'hd76aa478));
        chk("rst_s", 128'(bus.rnd_s), 128'(7));
        chk("rst_msg", 128'(bus.rnd_message), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        run_hash(0, "empty", EMPTY_FIN, 1'b1);
        wait_idle("empty");
        run_hash(1, "abc", ABC_FIN, 1'b1);
        wait_idle("abc");

        // Distinct message words make the schedule visible on rnd_message.
        push_drv(32'h11110000, 32'h11110001, 32'h11110005);
        run_hash(2, "distinct", '0, 1'b0);
        wait_idle("distinct");

        // start held high: ignored during RUN/DONE, re-accepted on the first IDLE edge.
        @(negedge clk);
        load_block(0);
        bus.start = 1'b1;
        dig_q.push_back('{"held1", expect_digest(EMPTY_FIN), 1'b1, cyc + 66});
        dig_q.push_back('{"held2", expect_digest(EMPTY_FIN), 1'b1, cyc + 132});
        repeat (10) @(negedge clk);
        chk("held_busy", 128'(bus.busy), 128'(1));
        repeat (61) @(negedge clk);
        bus.start = 1'b0;
        wait_idle("held");

        // Abort mid-hash with an asynchronous reset at step 30.
        @(negedge clk);
        load_block(2);
        bus.start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < c0 + 31) @(negedge clk);
        chk("abort_pre_sel", 128'(bus.rnd_sel), 128'(2'b01));
        chk("abort_pre_t", 128'(bus.rnd_t), 128'(32'h676f02d9));
        #1 rst = 1'b1;
        #1;
        chk("abort_busy", 128'(bus.busy), 128'(0));
        chk("abort_done", 128'(bus.done), 128'(0));
        chk("abort_rnd_b", 128'(bus.rnd_b), 128'(0));
        chk("abort_digest", bus.digest_out, 128'(0));
        chk("abort_t", 128'(bus.rnd_t), 128'(32'hd76aa478));
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("abort_idle_busy", 128'(bus.busy), 128'(0));

        run_hash(0, "after_abort", EMPTY_FIN, 1'b1);
        wait_idle("after_abort");
        chk("digest_hold", bus.digest_out, expect_digest(EMPTY_FIN));
        chk("drv_queue_drained", 128'(drv_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
